// File: rtl/bus_fabric.sv
// bus_fabric: picorv32 native-bus interconnect with base/mask decode, local error-status words
// and an optional per-access timeout (enabled by defining BUS_TIMEOUT_EN).

// state  | meaning
// IDLE   | waiting for m_valid; decode address and latch target into cur
// ACCESS | s_sel[cur] asserted, waiting for s_ready[cur] (or timeout expiry)
// LOCAL  | one-cycle access to the status words at ERR_ADDR / ERR_ADDR+4
// ERROR  | one-cycle error response; status registers are logged as it ends
module bus_fabric #(
    parameter int                    NSLAVES        = 4,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE     = {32'h8000_0010, 32'h8000_0008,
                                                       32'h8000_0000, 32'h0000_0000},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK     = {32'hffff_fffc, 32'hffff_fff8,
                                                       32'hffff_fffc, 32'hfffe_0000},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_ADDR       = 32'h8000_00f0,
    parameter logic [31:0]           ERR_RDATA      = 32'hdead_beef
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_valid,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_wstrb,
    output logic                    m_ready,
    output logic [31:0]             m_rdata,
    output logic [NSLAVES-1:0]      s_sel,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [NSLAVES-1:0]      s_ready,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    output logic                    bus_err
);

    localparam int IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, LOCAL, ERROR} state_t;

    state_t            state;
    logic [IDXW-1:0]   cur;
    logic [31:0]       addr_q;
    logic              wr_q;
    logic              local_hi;
    logic              via_timeout;

    logic [15:0]       err_count;
    logic              sticky;
    logic              last_timeout;
    logic [31:0]       err_addr;

    logic              is_local;
    logic              hit;
    logic [IDXW-1:0]   hit_idx;
    logic [NSLAVES-1:0] sel_onehot;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              expired;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    assign is_local = (m_addr == ERR_ADDR) || (m_addr == ERR_ADDR + 32'd4);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (cur == IDXW'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ready     = s_ready[i];
                sel_rdata     = s_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Down-counter reloaded every IDLE cycle; terminal count 0 in ACCESS means expiry.
    logic [15:0] tmr;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr <= '0;
        end else if (state == IDLE) begin
            tmr <= 16'(TIMEOUT_CYCLES - 1);
        end else if (state == ACCESS && !sel_ready && tmr != 16'd0) begin
            tmr <= tmr - 16'd1;
        end
    end

    assign expired = (state == ACCESS) && (tmr == 16'd0);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        s_sel   = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        bus_err = 1'b0;
        case (state)
            ACCESS: begin
                if (m_valid) begin
                    s_sel   = sel_onehot;
                    m_ready = sel_ready;
                    m_rdata = sel_rdata;
                end
            end
            LOCAL: begin
                m_ready = 1'b1;
                m_rdata = local_hi ? err_addr
                                   : {err_count, 14'b0, last_timeout, sticky};
            end
            ERROR: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
                bus_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            local_hi     <= 1'b0;
            via_timeout  <= 1'b0;
            err_count    <= '0;
            sticky       <= 1'b0;
            last_timeout <= 1'b0;
            err_addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        addr_q      <= m_addr;
                        wr_q        <= |m_wstrb;
                        local_hi    <= (m_addr == ERR_ADDR + 32'd4);
                        via_timeout <= 1'b0;
                        if (is_local) begin
                            state <= LOCAL;
                        end else if (hit) begin
                            cur   <= hit_idx;
                            state <= ACCESS;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked before expiry so a last-cycle completion wins.
                    if (!m_valid || sel_ready) begin
                        state <= IDLE;
                    end else if (expired) begin
                        via_timeout <= 1'b1;
                        state       <= ERROR;
                    end
                end
                LOCAL: begin
                    if (wr_q && !local_hi) begin
                        err_count    <= '0;
                        sticky       <= 1'b0;
                        last_timeout <= 1'b0;
                        err_addr     <= '0;
                    end
                    state <= IDLE;
                end
                ERROR: begin
                    if (err_count != 16'hffff) begin
                        err_count <= err_count + 16'd1;
                    end
                    sticky       <= 1'b1;
                    last_timeout <= via_timeout;
                    err_addr     <= addr_q;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: randomized and directed checks of bus_fabric against a transaction-level model
// of decode precedence, latency, timeout and the error-status words.
module tb_bus_fabric;

    localparam int          NS     = 4;
    localparam int          TO     = 8;
    localparam int          BUDGET = 200;
    localparam logic [31:0] ERRA   = 32'h8000_00f0;
    localparam logic [31:0] ERRD   = 32'hdead_beef;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // Slave 3 overlaps slaves 1/2 and the status words to exercise decode precedence.
    localparam logic [31:0] BASE_T [NS] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0008, 32'h8000_0000};
    localparam logic [31:0] MASK_T [NS] = '{32'hfffe_0000, 32'hffff_fffc, 32'hffff_fff8, 32'hffff_ff00};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m_valid = 1'b0;
    logic [31:0]       m_addr = '0;
    logic [31:0]       m_wdata = '0;
    logic [3:0]        m_wstrb = '0;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_sel;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [NS-1:0]     s_ready = '0;
    logic [NS*32-1:0]  s_rdata;
    logic              bus_err;
    logic [31:0]       rd_slot [NS];

    int vectors = 0;
    int miscompares = 0;

    int          mdl_count;
    bit          mdl_sticky;
    bit          mdl_last_to;
    logic [31:0] mdl_eaddr;

    always #5 clk = ~clk;

    always_comb begin
        s_rdata = '0;
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = rd_slot[i];
    end

    bus_fabric #(
        .NSLAVES        (NS),
        .SLAVE_BASE     ({32'h8000_0000, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hffff_ff00, 32'hffff_fff8, 32'hffff_fffc, 32'hfffe_0000}),
        .TIMEOUT_CYCLES (TO),
        .ERR_ADDR       (ERRA),
        .ERR_RDATA      (ERRD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .s_sel   (s_sel),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .bus_err (bus_err)
    );

    // ---------------- reference model ----------------
    function automatic int exp_target(input logic [31:0] a);
        if (a == ERRA || a == ERRA + 32'd4) return -2;
        for (int i = 0; i < NS; i++) if ((a & MASK_T[i]) == BASE_T[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] mdl_status();
        logic [15:0] c;
        c = mdl_count[15:0];
        return {c, 14'b0, mdl_last_to, mdl_sticky};
    endfunction

    task automatic mdl_clear();
        mdl_count = 0; mdl_sticky = 0; mdl_last_to = 0; mdl_eaddr = '0;
    endtask

    task automatic mdl_log(input logic [31:0] a, input bit to);
        if (mdl_count < 65535) mdl_count++;
        mdl_sticky = 1; mdl_last_to = to; mdl_eaddr = a;
    endtask

    // delay = number of s_sel cycles the slave waits before s_ready (1000 = never)
    task automatic predict(input logic [31:0] a, input logic [3:0] ws, input int delay,
                           output int e_lat, output logic [31:0] e_rd, output int e_err,
                           output int e_selc, output logic [NS-1:0] e_sel);
        int t;
        t = exp_target(a);
        e_sel = '0;
        if (t == -2) begin
            e_lat = 1; e_err = 0; e_selc = 0;
            e_rd = (a == ERRA + 32'd4) ? mdl_eaddr : mdl_status();
            if (a == ERRA && ws != 4'h0) mdl_clear();
        end else if (t == -1) begin
            e_lat = 1; e_err = 1; e_selc = 0; e_rd = ERRD;
            mdl_log(a, 1'b0);
        end else begin
            e_sel[t] = 1'b1;
            if (TO_EN && delay >= TO) begin
                e_selc = TO; e_lat = TO + 1; e_rd = ERRD; e_err = 1;
                mdl_log(a, 1'b1);
            end else begin
                e_selc = delay + 1; e_lat = delay + 1; e_rd = rd_slot[t]; e_err = 0;
            end
        end
    endtask

    // ---------------- driver: one core request, observations only ----------------
    task automatic drive_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             input int delay, input logic [NS-1:0] exp_sel,
                             output int lat, output logic [31:0] rd, output int errs,
                             output int selc, output bit bad);
        int cyc;
        bit done;
        lat = -1; rd = '0; errs = 0; selc = 0; bad = 0; done = 0; cyc = 0;
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
        while (!done && cyc < BUDGET) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (s_sel != '0) begin
                selc++;
                if (s_sel !== exp_sel) bad = 1;
            end
            s_ready = NS'($urandom) & ~exp_sel;
            if (exp_sel != '0 && s_sel == exp_sel && selc > delay) s_ready = s_ready | exp_sel;
            @(negedge clk);
            if (bus_err === 1'b1) errs++;
            if (m_ready === 1'b1) begin lat = cyc; rd = m_rdata; done = 1; end
            cyc++;
        end
        @(posedge clk); #1;
        m_valid = 1'b0; s_ready = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat, errs, selc; logic [31:0] rd; bit bad;
        reset = 1'b1; m_valid = 1'b1; m_addr = 32'h4000_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (s_sel !== '0) begin miscompares++; $display("FAIL reset_s_sel got %b want 0", s_sel); end
        vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL reset_m_ready got %b want 0", m_ready); end
        vectors++; if (m_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        @(posedge clk); #1;
        reset = 1'b0; m_valid = 1'b0;
        mdl_clear();
        drive_txn(ERRA, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h want 0", rd); end
        drive_txn(ERRA + 32'd4, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_errad got %h want 0", rd); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL reset_local_lat got %0d want 1", lat); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'h0000_0100, 32'h8000_0000, 32'h4000_0000, ERRA,
                                ERRA + 32'd4, 32'h8000_0004, 32'h8000_00f8, 32'h8000_000c};
        logic [3:0]  tw [8] = '{4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0};
        int          td [8] = '{0, 3, 0, 0, 0, 1, 0, 2};
        int lat, errs, selc, e_lat, e_err, e_selc; logic [31:0] rd, e_rd; logic [NS-1:0] e_sel; bit bad;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NS; i++) rd_slot[i] = $urandom;
            if (k == 0) rd_slot[0] = 32'h1234_5678;
            predict(ta[k], tw[k], td[k], e_lat, e_rd, e_err, e_selc, e_sel);
            drive_txn(ta[k], 32'h0000_003f, tw[k], td[k], e_sel, lat, rd, errs, selc, bad);
            vectors++; if (lat !== e_lat) begin miscompares++; $display("FAIL dir%0d_lat got %0d want %0d", k, lat, e_lat); end
            vectors++; if (rd !== e_rd) begin miscompares++; $display("FAIL dir%0d_rdata got %h want %h", k, rd, e_rd); end
            vectors++; if (errs !== e_err) begin miscompares++; $display("FAIL dir%0d_bus_err got %0d want %0d", k, errs, e_err); end
            vectors++; if (selc !== e_selc) begin miscompares++; $display("FAIL dir%0d_sel_cycles got %0d want %0d", k, selc, e_selc); end
            vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL dir%0d_wrong_sel got 1 want 0", k); end
            if (k == 0) begin
                vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL dir_slave0_data got %h want 12345678", rd); end
            end
            if (k == 3) begin
                vectors++; if (rd !== 32'h0001_0001) begin miscompares++; $display("FAIL dir_status got %h want 00010001", rd); end
            end
            if (k == 4) begin
                vectors++; if (rd !== 32'h4000_0000) begin miscompares++; $display("FAIL dir_err_addr got %h want 40000000", rd); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] ta [5] = '{ERRA, 32'h8000_0008, ERRA, 32'h8000_0008, ERRA};
        logic [3:0]  tw [5] = '{4'hf, 4'h0, 4'h0, 4'h0, 4'h0};
        int          td [5] = '{0, 1000, 0, TO - 1, 0};
        int lat, errs, selc, e_lat, e_err, e_selc; logic [31:0] rd, e_rd; logic [NS-1:0] e_sel; bit bad;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NS; i++) rd_slot[i] = $urandom;
            predict(ta[k], tw[k], td[k], e_lat, e_rd, e_err, e_selc, e_sel);
            drive_txn(ta[k], $urandom, tw[k], td[k], e_sel, lat, rd, errs, selc, bad);
            vectors++; if (lat !== e_lat) begin miscompares++; $display("FAIL to%0d_lat got %0d want %0d", k, lat, e_lat); end
            vectors++; if (rd !== e_rd) begin miscompares++; $display("FAIL to%0d_rdata got %h want %h", k, rd, e_rd); end
            vectors++; if (errs !== e_err) begin miscompares++; $display("FAIL to%0d_bus_err got %0d want %0d", k, errs, e_err); end
            vectors++; if (selc !== e_selc) begin miscompares++; $display("FAIL to%0d_sel_cycles got %0d want %0d", k, selc, e_selc); end
            vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL to%0d_wrong_sel got 1 want 0", k); end
            if (k == 1) begin
                vectors++; if (selc !== TO) begin miscompares++; $display("FAIL to_sel_len got %0d want %0d", selc, TO); end
            end
            if (k == 2 || k == 4) begin
                vectors++; if (rd !== 32'h0001_0003) begin miscompares++; $display("FAIL to_status%0d got %h want 00010003", k, rd); end
            end
        end
    endtask

    task automatic test_protocol();
        int lat, errs, selc, e_lat, e_err, e_selc; logic [31:0] rd, e_rd; logic [NS-1:0] e_sel; bit bad;
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h8000_0008; m_wstrb = 4'h0; s_ready = '0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (s_sel !== 4'b0100) begin miscompares++; $display("FAIL prot_sel got %b want 0100", s_sel); end
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(negedge clk);
        vectors++; if (s_sel !== '0) begin miscompares++; $display("FAIL prot_sel_drop got %b want 0", s_sel); end
        vectors++; if (m_ready !== 1'b0 || bus_err !== 1'b0) begin
            miscompares++; $display("FAIL prot_ready_err got %b%b want 00", m_ready, bus_err);
        end
        predict(ERRA, 4'h0, 0, e_lat, e_rd, e_err, e_selc, e_sel);
        drive_txn(ERRA, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (rd !== e_rd) begin miscompares++; $display("FAIL prot_status got %h want %h", rd, e_rd); end
    endtask

    task automatic test_reset_mid();
        int lat, errs, selc, e_lat, e_err, e_selc; logic [31:0] rd, e_rd; logic [NS-1:0] e_sel; bit bad;
        predict(32'h4000_0010, 4'h0, 0, e_lat, e_rd, e_err, e_selc, e_sel);
        drive_txn(32'h4000_0010, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (errs !== 1) begin miscompares++; $display("FAIL rmid_pre_err got %0d want 1", errs); end
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h8000_0000; m_wstrb = 4'h0; s_ready = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        vectors++; if (s_sel !== 4'b0010) begin miscompares++; $display("FAIL rmid_stall_sel got %b want 0010", s_sel); end
        @(posedge clk); #1;
        reset = 1'b1; m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (s_sel !== '0) begin miscompares++; $display("FAIL rmid_sel got %b want 0", s_sel); end
        vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_ready got %b want 0", m_ready); end
        mdl_clear();
        drive_txn(ERRA, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rmid_status got %h want 0", rd); end
        drive_txn(ERRA + 32'd4, 32'h0, 4'h0, 0, '0, lat, rd, errs, selc, bad);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rmid_errad got %h want 0", rd); end
        for (int i = 0; i < NS; i++) rd_slot[i] = $urandom;
        predict(32'h8000_0000, 4'h0, 1, e_lat, e_rd, e_err, e_selc, e_sel);
        drive_txn(32'h8000_0000, 32'h0, 4'h0, 1, e_sel, lat, rd, errs, selc, bad);
        vectors++; if (lat !== e_lat) begin miscompares++; $display("FAIL rmid_next_lat got %0d want %0d", lat, e_lat); end
        vectors++; if (rd !== e_rd) begin miscompares++; $display("FAIL rmid_next_rdata got %h want %h", rd, e_rd); end
    endtask

    task automatic test_random();
        int cat, sl, delay, lat, errs, selc, e_lat, e_err, e_selc;
        logic [31:0] a, rd, e_rd; logic [3:0] ws; logic [NS-1:0] e_sel; bit bad;
        for (int n = 0; n < 120; n++) begin
            cat = $urandom_range(0, 4);
            ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            case (cat)
                1: begin
                    a  = ERRA + 32'($urandom_range(0, 1) * 4);
                    ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                end
                2: a = $urandom & ~32'h3;
                3: a = 32'h8000_0000 | 32'($urandom_range(0, 63) * 4);
                default: begin
                    sl = $urandom_range(0, NS - 1);
                    a  = (BASE_T[sl] | ($urandom & ~MASK_T[sl])) & ~32'h3;
                end
            endcase
            delay = $urandom_range(0, 11);
            for (int i = 0; i < NS; i++) rd_slot[i] = $urandom;
            predict(a, ws, delay, e_lat, e_rd, e_err, e_selc, e_sel);
            drive_txn(a, $urandom, ws, delay, e_sel, lat, rd, errs, selc, bad);
            vectors++; if (lat !== e_lat) begin miscompares++; $display("FAIL rnd%0d_lat addr %h got %0d want %0d", n, a, lat, e_lat); end
            vectors++; if (rd !== e_rd) begin miscompares++; $display("FAIL rnd%0d_rdata addr %h got %h want %h", n, a, rd, e_rd); end
            vectors++; if (errs !== e_err) begin miscompares++; $display("FAIL rnd%0d_bus_err addr %h got %0d want %0d", n, a, errs, e_err); end
            vectors++; if (selc !== e_selc) begin miscompares++; $display("FAIL rnd%0d_sel_cycles addr %h got %0d want %0d", n, a, selc, e_selc); end
            vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_wrong_sel addr %h got 1 want 0", n, a); end
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) rd_slot[i] = '0;
        mdl_clear();
        test_reset();
        test_directed();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
